// File: rtl/dense_mult_feeder.sv
// rtl/dense_mult_feeder.sv - skewed operand replay feeder for the dense_mult systolic array
//
// Purpose: holds per-lane A and B operand streams in local buffers and, on start,
// replays them onto LANES = N+2 output lanes. Lane k starts k*LANE_SKEW cycles after
// lane 0, and elements on a lane are SPACING cycles apart. This produces the diagonal
// wavefronts the array expects.
//
// Optional feature macro: DENSE_FEEDER_LOOP_EN (adds the 'loop' input for back-to-back replay).
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   wr_en/wr_sel         buffer write strobe, 0 = A buffer, 1 = B buffer
//   wr_lane/wr_idx       target lane and element index; lanes above N+1 are ignored
//   wr_data              element value
//   len, start           elements per lane (clamped to DEPTH), stream start (IDLE only)
//   loop                 (DENSE_FEEDER_LOOP_EN only) replay again when high at the last stream cycle
//   busy, done, wr_err   streaming, one-cycle end pulse, one-cycle dropped-write pulse
//   a_out_bus/b_out_bus  per-lane operand data to the array
//   valid_bit_a_out/_b   per-lane valid bits to the array
module dense_mult_feeder #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SPACING    = 3,
  parameter int LANE_SKEW  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(N+2)-1:0]       wr_lane,
  input  logic [$clog2(DEPTH)-1:0]     wr_idx,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  input  logic                         start,
`ifdef DENSE_FEEDER_LOOP_EN
  input  logic                         loop,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err,
  output logic [DATA_WIDTH-1:0]        a_out_bus       [0:N+1],
  output logic                         valid_bit_a_out [0:N+1],
  output logic [DATA_WIDTH-1:0]        b_out_bus       [0:N+1],
  output logic                         valid_bit_b_out [0:N+1]
);

  localparam int LANES = N + 2;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);
  localparam int T_MAX = (N + 1) * LANE_SKEW + (DEPTH - 1) * SPACING;
  localparam int TW    = $clog2(T_MAX + 2);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t              state;
  logic [TW-1:0]       t_cnt;
  logic [LW-1:0]       l_reg;
  logic [LW-1:0]       l_next;
  int                  t_end;

  logic [DATA_WIDTH-1:0] buf_a [LANES][DEPTH];
  logic [DATA_WIDTH-1:0] buf_b [LANES][DEPTH];

  assign l_next = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

  // Last cycle of a stream: the final element of the most-skewed lane.
  always_comb begin
    t_end = (N + 1) * LANE_SKEW + (int'(l_reg) - 1) * SPACING;
  end

  assign busy = (state == S_STREAM);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      t_cnt  <= '0;
      l_reg  <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (state == S_STREAM);
      case (state)
        S_IDLE: begin
          if (start) begin
            l_reg <= l_next;
            t_cnt <= '0;
            // An empty stream still reports completion, without ever raising valid.
            state <= (l_next == '0) ? S_DONE : S_STREAM;
          end
        end
        S_STREAM: begin
          if (int'(t_cnt) == t_end) begin
`ifdef DENSE_FEEDER_LOOP_EN
            if (loop) begin
              t_cnt <= '0;
            end else begin
              state <= S_DONE;
            end
`else
            state <= S_DONE;
`endif
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffers are deliberately not reset so operands survive a mid-stream abort.
  always_ff @(posedge clk) begin
    if (wr_en && (state != S_STREAM) && (int'(wr_lane) <= N + 1)) begin
      if (wr_sel) begin
        buf_b[wr_lane][wr_idx] <= wr_data;
      end else begin
        buf_a[wr_lane][wr_idx] <= wr_data;
      end
    end
  end

  // Lane decode from the shared timebase. Reading the buffers combinationally lets a
  // write landing on the start edge be seen at t=0.
  always_comb begin
    int              u;
    logic [IW-1:0]   idx;
    u   = 0;
    idx = '0;
    for (int k = 0; k < LANES; k++) begin
      a_out_bus[k]       = '0;
      b_out_bus[k]       = '0;
      valid_bit_a_out[k] = 1'b0;
      valid_bit_b_out[k] = 1'b0;
      if (state == S_STREAM) begin
        u = int'(t_cnt) - k * LANE_SKEW;
        if ((u >= 0) && ((u % SPACING) == 0) && ((u / SPACING) < int'(l_reg))) begin
          idx                = IW'(u / SPACING);
          a_out_bus[k]       = buf_a[k][idx];
          b_out_bus[k]       = buf_b[k][idx];
          valid_bit_a_out[k] = 1'b1;
          valid_bit_b_out[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_mult_feeder.sv
// tb/tb_dense_mult_feeder.sv - self-checking bench for dense_mult_feeder
`timescale 1ns/1ps
module tb_dense_mult_feeder;
  localparam int N = 3, DW = 8, DEPTH = 8, SP = 3, SK = 1, LANES = N + 2;
  localparam int VW = 2 * LANES + 2 * LANES * DW + 3;
  localparam int OVA = 0, OVB = LANES, ODA = 2 * LANES, ODB = 2 * LANES + LANES * DW;
  localparam int OBUSY = VW - 3, ODONE = VW - 2, OERR = VW - 1;
  localparam int MAXT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [2:0] wr_lane = '0;
  logic [2:0] wr_idx = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0] len = '0;
`ifdef DENSE_FEEDER_LOOP_EN
  logic loop = 1'b0;
`endif
  logic busy, done, wr_err;
  logic [DW-1:0] a_out_bus [0:N+1];
  logic [DW-1:0] b_out_bus [0:N+1];
  logic valid_bit_a_out [0:N+1];
  logic valid_bit_b_out [0:N+1];

  logic [DW-1:0] ma [LANES][DEPTH];
  logic [DW-1:0] mb [LANES][DEPTH];
  logic [VW-1:0] obs [MAXT];
  logic [VW-1:0] expv [MAXT];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  dense_mult_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SPACING(SP), .LANE_SKEW(SK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
    .wr_idx(wr_idx), .wr_data(wr_data), .len(len), .start(start),
`ifdef DENSE_FEEDER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .wr_err(wr_err),
    .a_out_bus(a_out_bus), .valid_bit_a_out(valid_bit_a_out),
    .b_out_bus(b_out_bus), .valid_bit_b_out(valid_bit_b_out)
  );

  function automatic logic [VW-1:0] pack_outputs();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[OVA + k] = valid_bit_a_out[k];
      v[OVB + k] = valid_bit_b_out[k];
      v[ODA + k * DW +: DW] = a_out_bus[k];
      v[ODB + k * DW +: DW] = b_out_bus[k];
    end
    v[OBUSY] = busy;
    v[ODONE] = done;
    v[OERR]  = wr_err;
    return v;
  endfunction

  // Scatter each element to the cycle where it must appear on its lane.
  task automatic build_expected(input int l, input int passes);
    int te, per, tt;
    for (int t = 0; t < MAXT; t++) expv[t] = '0;
    if (l == 0) begin
      expv[0][ODONE] = 1'b1;
      return;
    end
    te  = (N + 1) * SK + (l - 1) * SP;
    per = te + 1;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < LANES; k++)
        for (int j = 0; j < l; j++) begin
          tt = p * per + k * SK + j * SP;
          expv[tt][OVA + k] = 1'b1;
          expv[tt][OVB + k] = 1'b1;
          expv[tt][ODA + k * DW +: DW] = ma[k][j];
          expv[tt][ODB + k * DW +: DW] = mb[k][j];
        end
    for (int t = 0; t < passes * per; t++) expv[t][OBUSY] = 1'b1;
    expv[passes * per][ODONE] = 1'b1;
  endtask

  task automatic write_elem(input logic sel, input int lane, input int idx, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_lane = 3'(lane); wr_idx = 3'(idx); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (lane < LANES) begin
      if (sel) mb[lane][idx] = d;
      else     ma[lane][idx] = d;
    end
  endtask

  task automatic start_stream(input int l);
    start = 1'b1; len = 4'(l);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    len = 4'($urandom_range(0, 15));
  endtask

  task automatic capture(input int n, input int poke_t, input int wr_t, input int rst_t, input int loop_n);
    for (int c = 0; c < n; c++) begin
      start = (c == poke_t);
      if (c == poke_t) len = 4'd1;
      wr_en = (c == wr_t);
      if (c == wr_t) begin
        wr_sel = 1'b0; wr_lane = 3'd0; wr_idx = 3'd0; wr_data = ~ma[0][0];
      end
      rst_n = (c != rst_t);
`ifdef DENSE_FEEDER_LOOP_EN
      loop = (c < loop_n);
`endif
      @(negedge clk);
      obs[c] = pack_outputs();
      @(posedge clk); #1;
    end
    start = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
`ifdef DENSE_FEEDER_LOOP_EN
    loop = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; len = 4'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (pack_outputs() !== '0) $display("FAIL reset cyc%0d got %h exp 0", c, pack_outputs());
      else passed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
  endtask

  task automatic test_directed();
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < 2; j++) begin
        write_elem(1'b0, k, j, 8'(16 * k + j));
        write_elem(1'b1, k, j, 8'($urandom));
      end
    start_stream(2);
    capture(10, -1, -1, -1, 0);
    build_expected(2, 1);
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL directed t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
    checks++;
    if ({obs[3][OVA], obs[3][ODA +: DW]} !== 9'h101) $display("FAIL lane0_t3 got %h exp 101", {obs[3][OVA], obs[3][ODA +: DW]});
    else passed++;
    checks++;
    if ({obs[7][OVA + 4], obs[7][ODA + 4 * DW +: DW]} !== 9'h141) $display("FAIL lane4_t7 got %h exp 141", {obs[7][OVA + 4], obs[7][ODA + 4 * DW +: DW]});
    else passed++;
  endtask

  task automatic test_random_streams();
    int l, te, lane, idx;
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < DEPTH; j++) begin
        write_elem(1'b0, k, j, 8'($urandom));
        write_elem(1'b1, k, j, 8'($urandom));
      end
    for (int k = LANES; k < 8; k++) write_elem(k[0], k, $urandom_range(0, 7), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      l  = $urandom_range(1, DEPTH);
      te = (N + 1) * SK + (l - 1) * SP;
      if (i % 2 == 1) begin
        // write landing on the start edge must be streamed
        lane = $urandom_range(0, LANES - 1); idx = $urandom_range(0, l - 1); d = 8'($urandom);
        wr_en = 1'b1; wr_sel = 1'(i / 2); wr_lane = 3'(lane); wr_idx = 3'(idx); wr_data = d;
        if (wr_sel) mb[lane][idx] = d;
        else        ma[lane][idx] = d;
      end
      start_stream(l);
      capture(te + 3, $urandom_range(1, te + 1), -1, -1, 0);
      build_expected(l, 1);
      for (int t = 0; t < te + 3; t++) begin
        checks++;
        if (obs[t] !== expv[t]) $display("FAIL random s%0d L=%0d t=%0d got %h exp %h", i, l, t, obs[t], expv[t]);
        else passed++;
      end
    end
  endtask

  task automatic test_write_during_stream();
    int te;
    te = (N + 1) * SK + 2 * SP;
    for (int r = 0; r < 2; r++) begin
      start_stream(3);
      capture(te + 3, -1, (r == 0) ? 1 : -1, -1, 0);
      build_expected(3, 1);
      if (r == 0) expv[2][OERR] = 1'b1;
      for (int t = 0; t < te + 3; t++) begin
        checks++;
        if (obs[t] !== expv[t]) $display("FAIL wr_during r%0d t=%0d got %h exp %h", r, t, obs[t], expv[t]);
        else passed++;
      end
    end
  endtask

  task automatic test_len_bounds();
    int te;
    start_stream(0);
    capture(3, -1, -1, -1, 0);
    build_expected(0, 1);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL len0 t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
    te = (N + 1) * SK + (DEPTH - 1) * SP;
    start_stream(9);
    capture(te + 3, -1, -1, -1, 0);
    build_expected(DEPTH, 1);
    for (int t = 0; t < te + 3; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL len9 t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_stream();
    int te;
    te = (N + 1) * SK + 3 * SP;
    start_stream(4);
    capture(te + 3, -1, -1, 2, 0);
    build_expected(4, 1);
    for (int t = 3; t < MAXT; t++) expv[t] = '0;
    for (int t = 0; t < te + 3; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL rst_mid t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
    start_stream(4);
    capture(te + 3, -1, -1, -1, 0);
    build_expected(4, 1);
    for (int t = 0; t < te + 3; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL rst_replay t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
  endtask

`ifdef DENSE_FEEDER_LOOP_EN
  task automatic test_loop();
    int per;
    per = (N + 1) * SK + 1;
    start_stream(1);
    capture(3 * per + 2, -1, -1, -1, 2 * per);
    build_expected(1, 3);
    for (int t = 0; t < 3 * per + 2; t++) begin
      checks++;
      if (obs[t] !== expv[t]) $display("FAIL loop t=%0d got %h exp %h", t, obs[t], expv[t]);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_streams();
    test_write_during_stream();
    test_len_bounds();
    test_reset_mid_stream();
`ifdef DENSE_FEEDER_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end
endmodule
